// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package md_pkg;

  localparam int CPU_WORD_W = 16;
  localparam int MD_WIDTH   = CPU_WORD_W;
  localparam int MD_ADDR_W  = 2;

  typedef enum logic [1:0] {
    MD_MULLO = 2'b00,
    MD_MULHI = 2'b01,
    MD_DIVQ  = 2'b10,
    MD_DIVR  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_mul(input md_op_e op);
    return (op == MD_MULLO) || (op == MD_MULHI);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shift-add multiply / restoring divide datapath; one iteration per step_i.
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_nxt_o
);

  // acc: product upper half / remainder; lo: multiplier->product lower half / dividend->quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  md_op_e           op_q, op_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;

  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[WIDTH-1]};
    if (load_i) begin
      op_d  = op_i;
      acc_d = '0;
      if (md_is_mul(op_i)) begin
        lo_d   = b_i;
        opnd_d = a_i;
      end else begin
        lo_d   = a_i;
        opnd_d = b_i;
      end
    end else if (step_i) begin
      if (md_is_mul(op_q)) begin
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end else if (shifted >= {1'b0, opnd_q}) begin
        acc_d = WIDTH'(shifted - {1'b0, opnd_q});
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result of the iteration in flight, so the top can register it on the final edge
  always_comb begin
    result_nxt_o = ((op_q == MD_MULHI) || (op_q == MD_DIVR)) ? acc_d : lo_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= MD_MULLO;
    end else begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide unit: FSM, iteration counter and
// register-file write port. Fixed 17-cycle start-to-write latency.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH  = MD_WIDTH,
  parameter int ADDR_W = MD_ADDR_W,
  parameter int CNT_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] dest_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WIDTH-1:0]  wr_data_q;
  logic              load;
  logic              step;
  logic              last_iter;
  logic [WIDTH-1:0]  result_nxt;

  assign load      = (state_q == MD_IDLE) && start;
  assign step      = (state_q == MD_RUN);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (reset_n),
    .load_i      (load),
    .step_i      (step),
    .op_i        (md_op_e'(op)),
    .a_i         (a),
    .b_i         (b),
    .result_nxt_o(result_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q <= MD_RUN;
            cnt_q   <= '0;
            dest_q  <= dest;
            busy_q  <= 1'b1;
          end
        end
        MD_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Write port is loaded on the 16th iteration edge so it is valid throughout DONE
          if (last_iter) begin
            state_q   <= MD_DONE;
            done_q    <= 1'b1;
            wr_addr_q <= dest_q;
            wr_data_q <= result_nxt;
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = done_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random operations
// checked against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  dest = '0;
  logic        busy, done, wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_addr = '0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .dest   (dest),
    .busy   (busy),
    .done   (done),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] x,
                                             input logic [15:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (y == 0) ? 16'hFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] d);
    logic [15:0] exp;
    exp = ref_result(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dest = d;
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); dest = 2'($urandom);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        chk("wr_en_run", wr_en, 0);
        chk("wr_data_hold", wr_data, last_data);
      end else if (k == 16) begin
        chk("wr_en_done", wr_en, 1);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 1);
        chk("wr_data", wr_data, exp);
        chk("wr_addr", wr_addr, d);
      end else begin
        chk("wr_en_after", wr_en, 0);
        chk("busy_after", busy, 0);
      end
    end
    last_data = exp;
    last_addr = d;
  endtask

  task automatic start_held;
    logic [1:0]  so [0:36];
    logic [15:0] sa [0:36];
    logic [15:0] sb [0:36];
    logic [1:0]  sd [0:36];
    int unsigned pulses;
    pulses = 0;
    for (int i = 0; i <= 36; i++) begin
      so[i] = 2'($urandom); sa[i] = 16'($urandom); sb[i] = 16'($urandom_range(0, 300));
      sd[i] = 2'($urandom);
    end
    @(negedge clk);
    start = 1'b1; op = so[0]; a = sa[0]; b = sb[0]; dest = sd[0];
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      op = so[k]; a = sa[k]; b = sb[k]; dest = sd[k];
      @(posedge clk); #1;
      if (wr_en) pulses++;
      if (k == 16 || k == 34) begin
        chk("held_wr_en", wr_en, 1);
        chk("held_wr_data", wr_data, ref_result(so[k-16], sa[k-16], sb[k-16]));
        chk("held_wr_addr", wr_addr, sd[k-16]);
        last_data = ref_result(so[k-16], sa[k-16], sb[k-16]);
        last_addr = sd[k-16];
      end else begin
        chk("held_no_wr", wr_en, 0);
      end
    end
    chk("held_pulse_count", pulses, 2);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("held_idle", busy, 0);
  endtask

  task automatic reset_mid_run;
    int unsigned pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0010; dest = 2'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_addr", wr_addr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wr_en) pulses++;
    end
    chk("rst_no_write", pulses, 0);
    last_data = '0;
    last_addr = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wr_en", wr_en, 0);
      chk("idle_wr_data", wr_data, 0);
      chk("idle_wr_addr", wr_addr, 0);
    end

    run_op(2'b00, 16'h1234, 16'h0010, 2'd2);
    run_op(2'b01, 16'h1234, 16'h0010, 2'd2);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 2'd1);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 2'd0);
    run_op(2'b10, 16'd100, 16'd7, 2'd3);
    run_op(2'b11, 16'd100, 16'd7, 2'd1);
    run_op(2'b10, 16'h00AB, 16'h0000, 2'd2);
    run_op(2'b11, 16'h00AB, 16'h0000, 2'd0);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] y;
      y = (i % 4 == 3) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      run_op(2'($urandom), 16'($urandom), y, 2'($urandom));
    end

    start_held();
    reset_mid_run();
    run_op(2'b10, 16'hFFFF, 16'h0003, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
